// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake on both sides.
// Stage 1 registers bit and group generate/propagate; stage 2 resolves carries and registers sum and flags.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  function automatic logic group_gen(input logic [GROUP-1:0] gs, input logic [GROUP-1:0] ps);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < GROUP; i++) acc = gs[i] | (ps[i] & acc);
    return acc;
  endfunction

  // Second-level lookahead: every group carry is a flat sum of products over GG/GP and c0.
  function automatic logic [NG:0] group_carries(input logic [NG-1:0] gg, input logic [NG-1:0] gp,
                                                input logic c0);
    logic [NG:0] gc;
    logic        acc;
    logic        prod;
    gc    = '0;
    gc[0] = c0;
    for (int k = 0; k < NG; k++) begin
      acc = 1'b0;
      for (int j = 0; j <= k; j++) begin
        prod = gg[j];
        for (int m = j + 1; m <= k; m++) prod = prod & gp[m];
        acc = acc | prod;
      end
      prod = c0;
      for (int m = 0; m <= k; m++) prod = prod & gp[m];
      gc[k+1] = acc | prod;
    end
    return gc;
  endfunction

  function automatic logic [WIDTH:0] bit_carries(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                                 input logic [NG:0] gc);
    logic [WIDTH:0] cv;
    int             idx;
    cv = '0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        idx = k * GROUP + i;
        if (i == 0) cv[idx] = gc[k];
        else        cv[idx] = g[idx-1] | (p[idx-1] & cv[idx-1]);
      end
    end
    cv[WIDTH] = gc[NG];
    return cv;
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic             in_fire;
  logic             s2_adv;

  logic [WIDTH-1:0] bx;
  logic             c0_d;
  logic [WIDTH-1:0] g_d, p_d;
  logic [NG-1:0]    gg_d, gp_d;

  logic [WIDTH-1:0] g_p1_q, p_p1_q;
  logic [NG-1:0]    gg_p1_q, gp_p1_q;
  logic             c0_p1_q;

  logic [NG:0]      gc;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, zero_d;

  logic [WIDTH-1:0] sum_p2_q;
  logic             cout_p2_q, ovf_p2_q, zero_p2_q;

  assign s2_adv   = vld_p1_q & (~vld_p2_q | out_ready);
  assign in_ready = ~vld_p1_q | s2_adv;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    vld_p1_d = vld_p1_q;
    if (in_fire)     vld_p1_d = 1'b1;
    else if (s2_adv) vld_p1_d = 1'b0;
    vld_p2_d = vld_p2_q;
    if (s2_adv)         vld_p2_d = 1'b1;
    else if (out_ready) vld_p2_d = 1'b0;
  end

  // Stage 0 -> 1: operand conditioning and first-level lookahead.
  always_comb begin
    bx   = sub ? ~b : b;
    c0_d = sub ? ~cin : cin;
    g_d  = a & bx;
    p_d  = a ^ bx;
    gg_d = '0;
    gp_d = '0;
    for (int k = 0; k < NG; k++) begin
      gg_d[k] = group_gen(g_d[k*GROUP +: GROUP], p_d[k*GROUP +: GROUP]);
      gp_d[k] = &p_d[k*GROUP +: GROUP];
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      g_p1_q  <= g_d;
      p_p1_q  <= p_d;
      gg_p1_q <= gg_d;
      gp_p1_q <= gp_d;
      c0_p1_q <= c0_d;
    end
  end

  // Stage 1 -> 2: carry resolution, sum and flags.
  always_comb begin
    gc     = group_carries(gg_p1_q, gp_p1_q, c0_p1_q);
    carry  = bit_carries(g_p1_q, p_p1_q, gc);
    sum_d  = p_p1_q ^ carry[WIDTH-1:0];
    cout_d = carry[WIDTH];
    ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    zero_d = ~|sum_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      sum_p2_q  <= '0;
      cout_p2_q <= 1'b0;
      ovf_p2_q  <= 1'b0;
      zero_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (s2_adv) begin
        sum_p2_q  <= sum_d;
        cout_p2_q <= cout_d;
        ovf_p2_q  <= ovf_d;
        zero_p2_q <= zero_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign sum       = sum_p2_q;
  assign cout      = cout_p2_q;
  assign ovf       = ovf_p2_q;
  assign zero      = zero_p2_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for the pipelined CLA adder: a 16-bit and a 4-bit instance share clock and reset.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid16 = 1'b0, in_ready16, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        out_valid16, out_ready16 = 1'b0, cout16, ovf16, zero16;

  logic        in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, sub4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, sum4;
  logic        out_valid4, out_ready4 = 1'b0, cout4, ovf4, zero4;

  int tests = 0;
  int fails = 0;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
    logic [15:0] yx;
    logic        c0;
    logic [16:0] r;
    logic        o;
    yx = s ? ~y : y;
    c0 = s ? ~ci : ci;
    r  = {1'b0, x} + {1'b0, yx} + {16'b0, c0};
    o  = (x[15] == yx[15]) && (r[15] != x[15]);
    return {r[16], o, (r[15:0] == 16'h0), r[15:0]};
  endfunction

  task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                         input logic tsub, output logic [15:0] rs, output logic rc,
                         output logic ro, output logic rz, output int lat);
    @(negedge clk);
    a16 = ta; b16 = tb_; cin16 = tcin; sub16 = tsub;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid16 = 1'b0;
    while (!out_valid16 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rs = sum16; rc = cout16; ro = ovf16; rz = zero16;
  endtask

  task automatic do_op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tcin,
                        output logic [3:0] rs, output logic rc, output logic ro,
                        output logic rz, output int lat);
    @(negedge clk);
    a4 = ta; b4 = tb_; cin4 = tcin; sub4 = 1'b0;
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid4 = 1'b0;
    while (!out_valid4 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rs = sum4; rc = cout4; ro = ovf4; rz = zero4;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (out_valid16 !== 1'b0) begin fails++; $display("FAIL rst_out_valid16 got %b want 0", out_valid16); end
    tests++; if (in_ready16 !== 1'b1) begin fails++; $display("FAIL rst_in_ready16 got %b want 1", in_ready16); end
    tests++; if (sum16 !== 16'h0) begin fails++; $display("FAIL rst_sum16 got %h want 0000", sum16); end
    tests++; if ({cout16, ovf16, zero16} !== 3'b000) begin fails++; $display("FAIL rst_flags16 got %b want 000", {cout16, ovf16, zero16}); end
    tests++; if (out_valid4 !== 1'b0) begin fails++; $display("FAIL rst_out_valid4 got %b want 0", out_valid4); end
    tests++; if ({sum4, cout4, ovf4, zero4} !== 7'h0) begin fails++; $display("FAIL rst_outs4 got %h want 0", {sum4, cout4, ovf4, zero4}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    logic [15:0] s; logic c, o, z; int lat;
    do_op16(16'h0001, 16'h0002, 1'b0, 1'b0, s, c, o, z, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL add_latency got %0d want 2", lat); end
    tests++; if ({s, c, o, z} !== {16'h0003, 3'b000}) begin fails++; $display("FAIL add_1_2 got %h c%b o%b z%b want 0003 c0 o0 z0", s, c, o, z); end
  endtask

  task automatic test_carry_ovf();
    logic [15:0] s; logic c, o, z; int lat;
    do_op16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {16'hFFFE, 3'b100}) begin fails++; $display("FAIL add_ffff_ffff got %h c%b o%b z%b want fffe c1 o0 z0", s, c, o, z); end
    do_op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {16'h8000, 3'b010}) begin fails++; $display("FAIL add_7fff_1 got %h c%b o%b z%b want 8000 c0 o1 z0", s, c, o, z); end
    do_op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {16'h0000, 3'b101}) begin fails++; $display("FAIL add_ripple got %h c%b o%b z%b want 0000 c1 o0 z1", s, c, o, z); end
  endtask

  task automatic test_subtract();
    logic [15:0] s; logic c, o, z; int lat;
    do_op16(16'h0005, 16'h0005, 1'b0, 1'b1, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {16'h0000, 3'b101}) begin fails++; $display("FAIL sub_5_5 got %h c%b o%b z%b want 0000 c1 o0 z1", s, c, o, z); end
    do_op16(16'h0003, 16'h0005, 1'b0, 1'b1, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {16'hFFFE, 3'b000}) begin fails++; $display("FAIL sub_3_5 got %h c%b o%b z%b want fffe c0 o0 z0", s, c, o, z); end
    do_op16(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {16'h7FFF, 3'b110}) begin fails++; $display("FAIL sub_8000_1 got %h c%b o%b z%b want 7fff c1 o1 z0", s, c, o, z); end
    do_op16(16'h0010, 16'h0003, 1'b1, 1'b1, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {16'h000C, 3'b100}) begin fails++; $display("FAIL sub_borrow_in got %h c%b o%b z%b want 000c c1 o0 z0", s, c, o, z); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [18:0] held;
    logic        stalled_prev, saw_block;
    int          in_idx, out_idx, cyc;
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom);
      vc[i] = 1'($urandom); vs[i] = 1'($urandom);
    end
    in_idx = 0; out_idx = 0; cyc = 0; stalled_prev = 1'b0; saw_block = 1'b0; held = '0;
    while (out_idx < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready16 = !(cyc >= 3 && cyc <= 6);
      in_valid16  = (in_idx < 8);
      if (in_idx < 8) begin
        a16 = va[in_idx]; b16 = vb[in_idx]; cin16 = vc[in_idx]; sub16 = vs[in_idx];
      end
      #1;
      if (stalled_prev && out_valid16) begin
        tests++;
        if ({cout16, ovf16, zero16, sum16} !== held) begin
          fails++; $display("FAIL stall_stable cyc %0d got %h want %h", cyc, {cout16, ovf16, zero16, sum16}, held);
        end
      end
      if (in_valid16 && !in_ready16) saw_block = 1'b1;
      if (out_valid16 && out_ready16) begin
        tests++;
        if ({cout16, ovf16, zero16, sum16} !== model16(va[out_idx], vb[out_idx], vc[out_idx], vs[out_idx])) begin
          fails++; $display("FAIL stream_result idx %0d got %h want %h", out_idx,
                            {cout16, ovf16, zero16, sum16}, model16(va[out_idx], vb[out_idx], vc[out_idx], vs[out_idx]));
        end
        out_idx++;
      end
      stalled_prev = out_valid16 && !out_ready16;
      held = {cout16, ovf16, zero16, sum16};
      if (in_valid16 && in_ready16) in_idx++;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    tests++; if (out_idx !== 8) begin fails++; $display("FAIL stream_count got %0d want 8", out_idx); end
    tests++; if (saw_block !== 1'b1) begin fails++; $display("FAIL stream_backpressure in_ready never dropped got %b want 1", saw_block); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic c, o, z; int lat;
    @(negedge clk);
    out_ready16 = 1'b0; in_valid16 = 1'b1;
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a16 = 16'h3333; b16 = 16'h4444;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    #1;
    tests++; if ({out_valid16, in_ready16} !== 2'b10) begin fails++; $display("FAIL pre_reset_full got v%b r%b want v1 r0", out_valid16, in_ready16); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({out_valid16, in_ready16} !== 2'b01) begin fails++; $display("FAIL async_reset got v%b r%b want v0 r1", out_valid16, in_ready16); end
    tests++; if (sum16 !== 16'h0) begin fails++; $display("FAIL async_reset_sum got %h want 0000", sum16); end
    @(negedge clk);
    rst = 1'b0; out_ready16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests++; if (out_valid16 !== 1'b0) begin fails++; $display("FAIL stale_after_reset cyc %0d got %b want 0", i, out_valid16); end
    end
    do_op16(16'h1234, 16'h1111, 1'b0, 1'b0, s, c, o, z, lat);
    tests++; if ({s, c, o, z, lat} !== {16'h2345, 3'b000, 32'd2}) begin fails++; $display("FAIL post_reset_add got %h c%b o%b z%b lat %0d want 2345 c0 o0 z0 lat 2", s, c, o, z, lat); end
  endtask

  task automatic test_width4();
    logic [3:0] s; logic c, o, z; int lat;
    logic [3:0] ra, rb; logic rc; logic [4:0] r; logic ro;
    do_op4(4'h1, 4'h2, 1'b0, s, c, o, z, lat);
    tests++; if ({s, c, z, lat} !== {4'h3, 2'b00, 32'd2}) begin fails++; $display("FAIL w4_1_2 got %h c%b z%b lat %0d want 3 c0 z0 lat 2", s, c, z, lat); end
    do_op4(4'h5, 4'h3, 1'b1, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {4'h9, 3'b010}) begin fails++; $display("FAIL w4_5_3_1 got %h c%b o%b z%b want 9 c0 o1 z0", s, c, o, z); end
    do_op4(4'hF, 4'hF, 1'b0, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {4'hE, 3'b100}) begin fails++; $display("FAIL w4_f_f got %h c%b o%b z%b want e c1 o0 z0", s, c, o, z); end
    do_op4(4'hA, 4'h5, 1'b1, s, c, o, z, lat);
    tests++; if ({s, c, o, z} !== {4'h0, 3'b101}) begin fails++; $display("FAIL w4_a_5_1 got %h c%b o%b z%b want 0 c1 o0 z1", s, c, o, z); end
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      r  = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
      ro = (ra[3] == rb[3]) && (r[3] != ra[3]);
      do_op4(ra, rb, rc, s, c, o, z, lat);
      tests++;
      if ({s, c, o, z} !== {r[3:0], r[4], ro, (r[3:0] == 4'h0)}) begin
        fails++; $display("FAIL w4_rand %h+%h+%b got %h c%b o%b z%b want %h c%b o%b", ra, rb, rc, s, c, o, z, r[3:0], r[4], ro);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ovf();
    test_subtract();
    test_back_to_back();
    test_reset_mid();
    test_width4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
